// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side command/response bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              sign;
  logic              gnt;
  logic              rvalid;
  logic [1:0]        width;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, width, sign, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, width, sign, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous-read memory port between requesters A and B
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave a,
  mem_port_arbiter_if.slave b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic [1:0]        mem_width,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_b_q, last_b_d, we_q, we_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d, mem_sign_q, mem_sign_d;
  logic [1:0]        mem_width_q, mem_width_d;
  logic              sel_b;
  always_comb begin
    sel_b       = b.req && (!a.req || !last_b_q);
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    we_d        = we_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_width_d = mem_width_q;
    mem_sign_d  = mem_sign_q;
    case (state_q)
      IDLE: if (a.req || b.req) begin
        last_b_d    = sel_b;
        we_d        = sel_b ? b.we    : a.we;
        mem_addr_d  = sel_b ? b.addr  : a.addr;
        mem_wdata_d = sel_b ? b.wdata : a.wdata;
        mem_width_d = sel_b ? b.width : a.width;
        mem_sign_d  = sel_b ? b.sign  : a.sign;
        mem_wren_d  = we_d;
        a_gnt_d     = !sel_b;
        b_gnt_d     = sel_b;
        state_d     = ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = CW'(RD_LAT);
      end
      WAIT: if (cnt_q == CW'(1)) begin
        a_rdata_d  = last_b_q ? a_rdata_q : mem_rdata;
        b_rdata_d  = last_b_q ? mem_rdata : b_rdata_q;
        a_rvalid_d = !last_b_q;
        b_rvalid_d = last_b_q;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_b_q    <= 1'b1;
      we_q        <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_width_q <= '0;
      mem_sign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      we_q        <= we_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_width_q <= mem_width_d;
      mem_sign_q  <= mem_sign_d;
    end
  end
  assign a.gnt     = a_gnt_q;
  assign b.gnt     = b_gnt_q;
  assign a.rvalid  = a_rvalid_q;
  assign b.rvalid  = b_rvalid_q;
  assign a.rdata   = a_rdata_q;
  assign b.rdata   = b_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign mem_width = mem_width_q;
  assign mem_sign  = mem_sign_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, timing and reset for RD_LAT=1 and RD_LAT=2
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  mem_addr, mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic        mem_wren, mem_wren2, mem_sign, mem_sign2;
  logic [1:0]  mem_width, mem_width2;
  int          n_chk = 0;
  int          n_pass = 0;
  int          wren_cnt;
  logic        exp_a;
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ia ();
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ib ();
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ia2 ();
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ib2 ();
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .a(ia), .b(ib),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_width(mem_width), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
  );
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .a(ia2), .b(ib2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wren(mem_wren2),
    .mem_width(mem_width2), .mem_sign(mem_sign2), .mem_rdata(mem_rdata2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  initial begin
    {ia.req, ia.we, ia.sign, ia.width, ia.addr, ia.wdata} = '0;
    {ib.req, ib.we, ib.sign, ib.width, ib.addr, ib.wdata} = '0;
    {ia2.req, ia2.we, ia2.sign, ia2.width, ia2.addr, ia2.wdata} = '0;
    {ib2.req, ib2.we, ib2.sign, ib2.width, ib2.addr, ib2.wdata} = '0;
    mem_rdata = '0;
    mem_rdata2 = '0;
    do_reset;
    chk("rst_a_gnt", ia.gnt, 0);
    chk("rst_a_rvalid", ia.rvalid, 0);
    chk("rst_b_rdata", ib.rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wren", mem_wren, 0);
    // single A read, RD_LAT=1
    ia.req = 1; ia.we = 0; ia.addr = 10'h004; ia.width = 2'd2; ia.sign = 1;
    tick;
    chk("t1_a_gnt", ia.gnt, 1);
    chk("t1_b_gnt", ib.gnt, 0);
    chk("t1_addr", mem_addr, 10'h004);
    chk("t1_width", mem_width, 2);
    chk("t1_sign", mem_sign, 1);
    chk("t1_wren", mem_wren, 0);
    ia.req = 0;
    tick;
    chk("t1_c2_gnt", ia.gnt, 0);
    chk("t1_c2_rvalid", ia.rvalid, 0);
    mem_rdata = 32'hDEADBEEF;
    tick;
    chk("t1_c3_rvalid", ia.rvalid, 1);
    chk("t1_c3_rdata", ia.rdata, 32'hDEADBEEF);
    chk("t1_c3_b_rvalid", ib.rvalid, 0);
    chk("t1_c3_b_rdata", ib.rdata, 0);
    mem_rdata = 32'h0;
    tick;
    chk("t1_c4_rvalid", ia.rvalid, 0);
    chk("t1_c4_rdata_hold", ia.rdata, 32'hDEADBEEF);
    // simultaneous reads after reset: A first
    do_reset;
    ia.req = 1; ia.we = 0; ia.addr = 10'h010; ia.sign = 0; ia.width = 0;
    ib.req = 1; ib.we = 0; ib.addr = 10'h020;
    tick;
    chk("t2_c1_a_gnt", ia.gnt, 1);
    chk("t2_c1_b_gnt", ib.gnt, 0);
    chk("t2_c1_addr", mem_addr, 10'h010);
    ia.req = 0;
    tick;
    mem_rdata = 32'h1111;
    tick;
    chk("t2_c3_a_rvalid", ia.rvalid, 1);
    chk("t2_c3_a_rdata", ia.rdata, 32'h1111);
    chk("t2_c3_b_gnt", ib.gnt, 0);
    mem_rdata = 32'h0;
    tick;
    chk("t2_c4_b_gnt", ib.gnt, 1);
    chk("t2_c4_addr", mem_addr, 10'h020);
    chk("t2_c4_a_rvalid", ia.rvalid, 0);
    ib.req = 0;
    tick;
    mem_rdata = 32'h2222;
    tick;
    chk("t2_c6_b_rvalid", ib.rvalid, 1);
    chk("t2_c6_b_rdata", ib.rdata, 32'h2222);
    chk("t2_c6_a_rvalid", ia.rvalid, 0);
    chk("t2_c6_a_rdata", ia.rdata, 32'h1111);
    mem_rdata = 32'h0;
    // both hold write requests: alternate A,B,A,B every 2 cycles
    ia.req = 1; ia.we = 1; ia.addr = 10'h100; ia.wdata = 32'hA0A0;
    ib.req = 1; ib.we = 1; ib.addr = 10'h200; ib.wdata = 32'hB0B0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      exp_a = ((i - 1) / 2) % 2 == 0;
      if (i % 2 == 1) begin
        chk($sformatf("t3_c%0d_a_gnt", i), ia.gnt, exp_a);
        chk($sformatf("t3_c%0d_b_gnt", i), ib.gnt, !exp_a);
        chk($sformatf("t3_c%0d_wren", i), mem_wren, 1);
        chk($sformatf("t3_c%0d_addr", i), mem_addr, exp_a ? 10'h100 : 10'h200);
        chk($sformatf("t3_c%0d_wdata", i), mem_wdata, exp_a ? 32'hA0A0 : 32'hB0B0);
      end else begin
        chk($sformatf("t3_c%0d_gnts", i), {ia.gnt, ib.gnt, mem_wren}, 0);
        chk($sformatf("t3_c%0d_addr_hold", i), mem_addr, exp_a ? 10'h100 : 10'h200);
      end
      chk($sformatf("t3_c%0d_rvalid", i), {ia.rvalid, ib.rvalid}, 0);
    end
    ia.req = 0; ib.req = 0;
    tick;
    chk("t3_a_rdata_kept", ia.rdata, 32'h1111);
    chk("t3_b_rdata_kept", ib.rdata, 32'h2222);
    // B write to the top address
    ib.req = 1; ib.we = 1; ib.addr = 10'h3FF; ib.wdata = 32'h12345678;
    wren_cnt = 0;
    tick;
    chk("t4_b_gnt", ib.gnt, 1);
    chk("t4_wren", mem_wren, 1);
    chk("t4_addr", mem_addr, 10'h3FF);
    chk("t4_wdata", mem_wdata, 32'h12345678);
    ib.req = 0;
    for (int i = 0; i < 4; i++) begin
      wren_cnt += int'(mem_wren);
      chk($sformatf("t4_rvalid_%0d", i), {ia.rvalid, ib.rvalid}, 0);
      tick;
    end
    chk("t4_wren_cycles", wren_cnt, 1);
    // reset asserted during WAIT of an A read
    ia.req = 1; ia.we = 0; ia.addr = 10'h055;
    tick;
    chk("t5_a_gnt", ia.gnt, 1);
    ia.req = 0;
    tick;
    mem_rdata = 32'h5555;
    rst = 1'b0;
    #1;
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_a_rdata", ia.rdata, 0);
    chk("t5_rst_b_rdata", ib.rdata, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_no_rvalid_%0d", i), ia.rvalid, 0);
      tick;
    end
    ia.req = 1; ia.addr = 10'h066;
    tick;
    chk("t5b_a_gnt", ia.gnt, 1);
    chk("t5b_addr", mem_addr, 10'h066);
    ia.req = 0;
    tick;
    mem_rdata = 32'h6666;
    tick;
    chk("t5b_c3_rvalid", ia.rvalid, 1);
    chk("t5b_c3_rdata", ia.rdata, 32'h6666);
    // RD_LAT=2 instance
    ia2.req = 1; ia2.we = 0; ia2.addr = 10'h0AB;
    tick;
    chk("t6_a_gnt", ia2.gnt, 1);
    chk("t6_addr", mem_addr2, 10'h0AB);
    ia2.req = 0;
    tick;
    chk("t6_c2_rvalid", ia2.rvalid, 0);
    mem_rdata2 = 32'h0BAD0BAD;
    tick;
    chk("t6_c3_rvalid", ia2.rvalid, 0);
    mem_rdata2 = 32'hCAFEF00D;
    tick;
    chk("t6_c4_rvalid", ia2.rvalid, 1);
    chk("t6_c4_rdata", ia2.rdata, 32'hCAFEF00D);
    mem_rdata2 = 32'h0;
    tick;
    chk("t6_c5_rvalid", ia2.rvalid, 0);
    chk("t6_c5_rdata_hold", ia2.rdata, 32'hCAFEF00D);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
